piso_serializer: RTL and testbench

- Parallel-in/serial-out shifter built on asynchronously reset D flip-flops.
- Transmit-side counterpart to the team's serial capture flops.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clk, with a per-bit valid and an end-of-word pulse.
- Sits between a parallel producer and a single-wire serial link.

---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer and its bit counter.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int PISO_WIDTH_DEF = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag at NBITS-1.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int NBITS = PISO_WIDTH_DEF,
    parameter int CW    = clog2(NBITS + 1)
) (
    input  logic          clk,
    input  logic          reset_al_in,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CW'(1);
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Valid/ready word in, one bit per clk out with per-bit valid and end-of-word pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_al_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             ser_valid_out,
    output logic             done_out
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] PRELAST = CW'(NBITS - 2);

    state_t           state, state_nxt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] load_word;
    logic [CW-1:0]    count;
    logic             terminal;
    logic             accept;
    logic             advance;

`ifdef PISO_PARITY_EN
    // Parity rides at the tail of the word so it leaves after the last data bit.
    assign load_word = MSB_FIRST ? {data_in, ^data_in} : {^data_in, data_in};
`else
    assign load_word = data_in;
`endif

    function automatic logic head(input logic [NBITS-1:0] w);
        return MSB_FIRST ? w[NBITS-1] : w[0];
    endfunction

    function automatic logic [NBITS-1:0] shifted(input logic [NBITS-1:0] w);
        return MSB_FIRST ? {w[NBITS-2:0], 1'b0} : {1'b0, w[NBITS-1:1]};
    endfunction

    assign ready_out = (state == ST_IDLE) | ((state == ST_SHIFT) & terminal);
    assign accept    = valid_in & ready_out;
    assign advance   = (state == ST_SHIFT) & ~terminal;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (terminal) state_nxt = accept ? ST_SHIFT : ST_IDLE;
        endcase
    end

    piso_bit_counter #(
        .NBITS (NBITS),
        .CW    (CW)
    ) u_cnt (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .clear       (accept),
        .enable      (advance),
        .count       (count),
        .terminal    (terminal)
    );

    // The head bit goes straight to the ser_out register, so shreg holds what is left.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            shreg         <= '0;
            ser_out       <= 1'b0;
            ser_valid_out <= 1'b0;
            done_out      <= 1'b0;
        end else if (accept) begin
            shreg         <= shifted(load_word);
            ser_out       <= head(load_word);
            ser_valid_out <= 1'b1;
            done_out      <= 1'b0;
        end else if (advance) begin
            shreg         <= shifted(shreg);
            ser_out       <= head(shreg);
            ser_valid_out <= 1'b1;
            done_out      <= (count == PRELAST);
        end else begin
            ser_out       <= 1'b0;
            ser_valid_out <= 1'b0;
            done_out      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one producer.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset_al_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic [1:0]   ready, ser, sv, done;

    int total = 0;
    int bad = 0;
    int rem = 0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_al_in(reset_al_in), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready[0]), .ser_out(ser[0]), .ser_valid_out(sv[0]), .done_out(done[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_al_in(reset_al_in), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready[1]), .ser_out(ser[1]), .ser_valid_out(sv[1]), .done_out(done[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Expected stream straight from the word: bit order, then parity, done on the last.
    task automatic push_word(input logic [W-1:0] d);
        logic bm, bl;
        for (int i = 0; i < NB; i++) begin
            if (i < W) begin
                bm = d[W-1-i];
                bl = d[i];
            end else begin
                bm = ^d;
                bl = ^d;
            end
            q0.push_back({(i == NB - 1), bm});
            q1.push_back({(i == NB - 1), bl});
        end
    endtask

    // Called just after a falling edge; rem = bits still to show, current one included.
    task automatic drive(input logic v, input logic [W-1:0] d);
        logic acc;
        check("ready_msb", ready[0], rem <= 1);
        check("ready_lsb", ready[1], rem <= 1);
        valid_in = v;
        data_in  = d;
        acc = v && (rem <= 1);
        if (acc) push_word(d);
        @(posedge clk);
        if (acc) rem = NB;
        else if (rem > 0) rem = rem - 1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("valid_msb", sv[0], 1'b1);
                check("bit_msb", ser[0], e[0]);
                check("done_msb", done[0], e[1]);
            end else begin
                check("idle_valid_msb", sv[0], 1'b0);
                check("idle_bit_msb", ser[0], 1'b0);
                check("idle_done_msb", done[0], 1'b0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("valid_lsb", sv[1], 1'b1);
                check("bit_lsb", ser[1], e[0]);
                check("done_lsb", done[1], e[1]);
            end else begin
                check("idle_valid_lsb", sv[1], 1'b0);
                check("idle_bit_lsb", ser[1], 1'b0);
                check("idle_done_lsb", done[1], 1'b0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready_msb", ready[0], 1'b1);
        check("rst_ready_lsb", ready[1], 1'b1);
        reset_al_in = 1'b1;
        drive(1'b0, '0);

        drive(1'b1, 8'hA5);
        repeat (NB + 2) drive(1'b0, W'($urandom));

        drive(1'b1, 8'h01);
        repeat (NB - 1) drive(1'b0, W'($urandom));
        drive(1'b1, 8'h80);
        repeat (NB + 2) drive(1'b0, '0);

        repeat (40) drive(1'b1, W'($urandom));
        repeat (NB + 1) drive(1'b0, '0);

        drive(1'b1, 8'h07);
        repeat (NB) drive(1'b0, '0);
        drive(1'b1, 8'h03);
        repeat (NB + 1) drive(1'b0, '0);

        // Abort 8'hFF while bit 4 is on the wire.
        drive(1'b1, 8'hFF);
        repeat (4) drive(1'b0, '0);
        #2;
        reset_al_in = 1'b0;
        #1;
        check("abort_valid_msb", sv[0], 1'b0);
        check("abort_valid_lsb", sv[1], 1'b0);
        check("abort_bit_msb", ser[0], 1'b0);
        check("abort_bit_lsb", ser[1], 1'b0);
        check("abort_done_msb", done[0], 1'b0);
        check("abort_done_lsb", done[1], 1'b0);
        q0.delete();
        q1.delete();
        rem = 0;
        repeat (2) @(negedge clk);
        #1;
        reset_al_in = 1'b1;
        repeat (2) drive(1'b0, '0);

        repeat (300) drive($urandom_range(0, 3) != 0, W'($urandom));
        repeat (NB + 2) drive(1'b0, '0);

        check("drained_msb", q0.size() == 0, 1'b1);
        check("drained_lsb", q1.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
